parity_stream_unit: RTL

- Parametrised, clocked successor to the team's combinational parity generator.
- Accepts a stream of DATA_W-bit words framed by a last flag over a valid/ready handshake.
- Generates or checks per-word parity (even or odd) and, once per frame, emits a summary: frame parity, word count and per-word parity-error count.
- Sits between a producer of parity-protected words and a status/CSR consumer.

---
 rtl/parity_stream_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/parity_stream_unit.sv
// Per-word parity generate/check over a framed valid/ready stream, with one summary per frame.
// word_par_o one cycle after accept; summary valid after the last accepted word and held until out_ready_i.
module parity_stream_unit #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              mode_i,
   input  logic              odd_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_par_i,
   input  logic              in_last_i,
   output logic              word_par_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_parity_o,
   output logic [CNT_W-1:0]  out_len_o,
   output logic [CNT_W-1:0]  out_err_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESULT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic             mode_q;
   logic             odd_q;
   logic             acc_q;
   logic             word_par_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] err_q;

   logic accept;
   logic mode_eff;
   logic odd_eff;
   logic p;
   logic mismatch;

   // The first word of a frame uses the live config; later words use the latched copy.
   always_comb begin
      mode_eff = mode_q;
      odd_eff  = odd_q;
      if (state == S_IDLE) begin
         mode_eff = mode_i;
         odd_eff  = odd_i;
      end
      accept   = in_valid_i && in_ready_q;
      p        = (^in_data_i) ^ odd_eff;
      mismatch = mode_eff && (p != in_par_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         mode_q      <= 1'b0;
         odd_q       <= 1'b0;
         acc_q       <= 1'b0;
         word_par_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         len_q       <= '0;
         err_q       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mode_q     <= mode_i;
                  odd_q      <= odd_i;
                  len_q      <= CNT_ONE;
                  acc_q      <= p;
                  err_q      <= mismatch ? CNT_ONE : '0;
                  word_par_q <= p;
                  if (in_last_i) begin
                     state       <= S_RESULT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= S_ACCUM;
                  end
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  if (len_q != CNT_MAX) len_q <= len_q + CNT_ONE;
                  if (mismatch && (err_q != CNT_MAX)) err_q <= err_q + CNT_ONE;
                  acc_q      <= acc_q ^ p;
                  word_par_q <= p;
                  if (in_last_i) begin
                     state       <= S_RESULT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            S_RESULT: begin
               // No bypass: the next frame is accepted only from IDLE, one cycle later.
               if (out_ready_i) begin
                  state       <= S_IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  len_q       <= '0;
                  err_q       <= '0;
                  acc_q       <= 1'b0;
               end
            end
            default: begin
               state       <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = out_valid_q;
   assign word_par_o    = word_par_q;
   assign out_parity_o  = acc_q;
   assign out_len_o     = len_q;
   assign out_err_cnt_o = err_q;

endmodule
